// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between the MEM stage and a 32-bit
// word-addressed data memory. Sub-word stores use read-modify-write and
// loads are sign/zero-extended.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined,
// misaligned half/word accesses are trapped. When it is undefined, they are
// aligned down.
module lsu_ctrl #(
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, RESP} state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W+1:0]  addr_reg;
  logic [1:0]         size_reg;
  logic               unsigned_reg;
  logic [31:0]        wdata_reg;
  logic [31:0]        word_reg;
  logic [31:0]        rdata_reg;
  logic               err_reg;
  logic               accept;
  logic               misalign;
  logic [31:0]        load_ext;
  logic [31:0]        merged;
  logic [31:0]        wdata_rep;
  logic [3:0]         byte_en;
  logic [1:0]         lane_off;
  logic [31:0]        shifted;
  logic               is_byte, is_half;
  logic               unused_addr_bits;

  // Upper address bits lie outside the memory and are deliberately dropped.
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign accept    = (state_reg == IDLE) && req_valid;
  assign req_ready = (state_reg == IDLE);
  assign stall     = !req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Size decode from the registered request; size 11 behaves as a word.
  assign is_byte  = (size_reg == 2'b00);
  assign is_half  = (size_reg == 2'b01);
  // Half accesses use only addr[1], which also aligns an odd half down.
  assign lane_off = is_byte ? addr_reg[1:0] : {addr_reg[1], 1'b0};

  // Byte enables and replicated store data per little-endian lane.
  always_comb begin
    byte_en   = 4'b1111;
    wdata_rep = wdata_reg;
    if (is_byte) begin
      byte_en   = 4'b0001 << addr_reg[1:0];
      wdata_rep = {4{wdata_reg[7:0]}};
    end else if (is_half) begin
      byte_en   = addr_reg[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{wdata_reg[15:0]}};
    end
  end

  // Merge new store lanes into the word read back during RMW_RD.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = byte_en[gi] ? wdata_rep[8*gi +: 8]
                                             : word_reg[8*gi +: 8];
    end
  endgenerate

  // Extract and extend the addressed lane of the returned word.
  always_comb begin
    shifted  = mem_read_data >> {lane_off, 3'b000};
    load_ext = mem_read_data;
    if (is_byte)
      load_ext = unsigned_reg ? {24'h0, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
    else if (is_half)
      load_ext = unsigned_reg ? {16'h0, shifted[15:0]}
                              : {{16{shifted[15]}}, shifted[15:0]};
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (misalign)                 state_next = RESP;
          else if (!req_write)          state_next = RD;
          else if (req_size[1])         state_next = WR;
          else                          state_next = RMW_RD;
        end
      end
      RD:      state_next = RESP;
      RMW_RD:  state_next = RMW_WR;
      RMW_WR:  state_next = RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and request registers; reset drops any in-flight access at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      size_reg     <= 2'b00;
      unsigned_reg <= 1'b0;
      wdata_reg    <= 32'h0;
      word_reg     <= 32'h0;
      rdata_reg    <= 32'h0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg     <= req_addr[ADDR_W+1:0];
        size_reg     <= req_size;
        unsigned_reg <= req_unsigned;
        wdata_reg    <= req_wdata;
        rdata_reg    <= 32'h0;
        err_reg      <= misalign;
      end
      if (state_reg == RD)     rdata_reg <= load_ext;
      if (state_reg == RMW_RD) word_reg  <= mem_read_data;
    end
  end

  // Memory strobes depend only on the state and the registered request.
  assign mem_read       = (state_reg == RD) || (state_reg == RMW_RD);
  assign mem_write      = (state_reg == WR) || (state_reg == RMW_WR);
  assign mem_address    = (mem_read || mem_write)
                          ? {{(32-ADDR_W){1'b0}}, addr_reg[ADDR_W+1:2]} : 32'h0;
  assign mem_write_data = (state_reg == WR)     ? wdata_reg :
                          (state_reg == RMW_WR) ? merged    : 32'h0;

  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = resp_valid ? rdata_reg : 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
  assign resp_err   = resp_valid && err_reg;
`else
  assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with a scoreboard of expected
// responses and a behavioural 32-word data memory.
module tb_lsu_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:31];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int both_cnt = 0;
  int resp_cnt = 0;
  int n_txn    = 0;
  int wr_before;
  int rd_before;
  int resp_before;

  lsu_ctrl #(.ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall), .mem_read(mem_read),
    .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_read_data = mem[mem_address[4:0]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[4:0]] = mem_write_data;
  end

  always @(negedge clk) begin
    if (mem_read)              rd_cnt++;
    if (mem_write)             wr_cnt++;
    if (mem_read && mem_write) both_cnt++;
    if (resp_valid)            resp_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input string name, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    exp_t e;
    exp_t g;
    int   cyc;
    logic seen;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb.push_back(e);
    n_txn++;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    check({name, "_ready"}, {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'hA5A5A5A5;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    g = sb.pop_front();
    check({name, "_seen"}, {31'h0, seen}, 32'h1);
    check({name, "_rdata"}, resp_rdata, g.rdata);
    check({name, "_err"}, {31'h0, resp_err}, {31'h0, g.err});
    check({name, "_lat"}, cyc, g.lat);
    $display("txn %s addr=%h wdata=%h rdata=%h err=%0b lat=%0d", name, addr, wdata,
             resp_rdata, resp_err, cyc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[3] = 32'h00000003;
    mem[5] = 32'h11223344;
    reset = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'hCAFEF00D;

    // Reset held with a pending store request.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_resp_err", {31'h0, resp_err}, 32'h0);
      check("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
      check("rst_mem_address", mem_address, 32'h0);
      check("rst_mem_wdata", mem_write_data, 32'h0);
      check("rst_ready_stall", {30'h0, req_ready, stall}, 32'h2);
    end
    check("rst_mem4", mem[4], 32'h0);
    $display("txn reset_hold cycles=3 ready=%0b", req_ready);
    req_valid = 1'b0;
    reset = 1'b1;

    wr_before = wr_cnt;
    issue("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check("sw_mem4", mem[4], 32'hDEADBEEF);
    check("sw_wr_cycles", wr_cnt - wr_before, 1);
    issue("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    issue("lb_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
    issue("lbu_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2);
    issue("lh_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2);

    wr_before = wr_cnt;
    issue("sb_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000005A, 32'h0, 1'b0, 3);
    check("sb_mem4", mem[4], 32'hDEAD5AEF);
    check("sb_wr_cycles", wr_cnt - wr_before, 1);

    issue("sh_16", 1'b1, 2'b01, 1'b0, 32'h16, 32'h0000A5C3, 32'h0, 1'b0, 3);
    check("sh_mem5", mem[5], 32'hA5C33344);
    issue("lhu_16", 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 32'h0000A5C3, 1'b0, 2);
    issue("lb_17", 1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 32'hFFFFFFA5, 1'b0, 2);
    issue("lw_size3", 1'b0, 2'b11, 1'b1, 32'h14, 32'h0, 32'hA5C33344, 1'b0, 2);

    rd_before = rd_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
    issue("lw_0e", 1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, 32'h0, 1'b1, 1);
    check("lw_0e_no_read", rd_cnt - rd_before, 0);
`else
    issue("lw_0e", 1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, 32'h00000003, 1'b0, 2);
    check("lw_0e_reads", rd_cnt - rd_before, 1);
`endif

    // Reset in RMW_RD aborts a byte store.
    wr_before   = wr_cnt;
    resp_before = resp_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h00000077;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("abort_in_rmw_rd", {31'h0, mem_read}, 32'h1);
    reset = 1'b0;
    #1;
    check("abort_ready", {31'h0, req_ready}, 32'h1);
    check("abort_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_mem4", mem[4], 32'hDEAD5AEF);
    check("abort_no_write", wr_cnt - wr_before, 0);
    check("abort_no_resp", resp_cnt - resp_before, 0);
    $display("txn abort_sb_11 mem4=%h", mem[4]);
    issue("lw_after_abort", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD5AEF, 1'b0, 2);

    check("no_rd_wr_overlap", both_cnt, 0);
    check("resp_count", resp_cnt, n_txn);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: ADDR_W, 5, word-index width of the downstream data memory (2^ADDR_W words of 32 bits).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  MEM-stage access request.
REQ-005 req_ready  out  1  request accepted when req_valid&&req_ready at a clk edge.
REQ-006 req_write  in  1  1=store, 0=load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data; sub-word data taken from LSBs.
REQ-011 resp_valid  out  1  one-cycle completion pulse, one per accepted request.
REQ-012 resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores.
REQ-013 resp_err  out  1  misaligned-access flag, valid with resp_valid.
REQ-014 stall  out  1  pipeline hold; equals !req_ready.
REQ-015 mem_read, mem_write  out  1 each  strobes to the data memory.
REQ-016 mem_address  out  32  word index = req_addr[ADDR_W+1:2], zero-extended.
REQ-017 mem_write_data  out  32  full word to write.
REQ-018 mem_read_data  in  32  word returned by the data memory in the same cycle as mem_read.

Function
REQ-019 States: IDLE, RD, RMW_RD, RMW_WR, WR, RESP; req_ready=1 only in IDLE.
REQ-020 On accept, address, size, unsigned flag and wdata are registered; the request inputs are ignored until the FSM next returns to IDLE.
REQ-021 Load: IDLE->RD (mem_read=1; mem_read_data captured at the end of the cycle)->RESP; resp_valid two cycles after accept.
REQ-022 Word store: IDLE->WR (mem_write=1 for exactly one cycle)->RESP.
REQ-023 Byte/half store: IDLE->RMW_RD (mem_read=1, word captured)->RMW_WR (mem_write=1, merged word)->RESP; only the addressed lanes are modified.
REQ-024 Lane selection is little-endian: byte lane = addr[1:0]; half lane = addr[1].
REQ-025 Load extension: byte/half sign- or zero-extended per req_unsigned; word returned unchanged.
REQ-026 RESP lasts one cycle, then returns to IDLE; a new request can be accepted on the following edge.
REQ-027 mem_read and mem_write are never asserted in the same cycle, and are both 0 in IDLE and RESP.
REQ-028 mem_* outputs are decoded from the state and the registered request only, with no combinational path from req_*.

Reset
REQ-029 When reset=0, the FSM is forced to IDLE immediately, without waiting for a clock edge.
REQ-030 While reset=0: resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0, req_ready=1, stall=0.
REQ-031 Reset during RD, RMW_RD or RMW_WR aborts the access; no mem_write occurs and no resp_valid is produced for it.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 goes IDLE->RESP with resp_err=1 and resp_rdata=0; no mem strobe is asserted.
REQ-033 Macro not defined: misaligned addresses are aligned down (half: addr[0] ignored; word: addr[1:0] ignored), and resp_err is tied to 0.

Verification
REQ-034 Hold reset=0 for 3 cycles with req_valid=1 -> all outputs at their reset values, no mem strobe, req_ready=1.
REQ-035 Word store 0xDEADBEEF at 0x10, then word load at 0x10 -> mem[4]=0xDEADBEEF; load resp_rdata=0xDEADBEEF two cycles after accept.
REQ-036 Byte load at 0x13 with unsigned=0 -> 0xFFFFFFDE; with unsigned=1 -> 0x000000DE; half load at 0x12 with unsigned=0 -> 0xFFFFDEAD.
REQ-037 Byte store 0x5A at 0x11 over 0xDEADBEEF -> mem[4]=0xDEAD5AEF; mem_write high for exactly 1 cycle; resp_valid 3 cycles after accept.
REQ-038 Word load at 0x0E with mem[3]=3 -> with the macro: resp_err=1 one cycle after accept and no mem_read; without the macro: resp_rdata=3.
REQ-039 Assert reset in RMW_RD during a byte store to 0x11 -> mem[4] unchanged, no resp_valid; the next request is accepted normally after release.
